spi_byte_slave: RTL

SPI mode-0 (CPOL=0, CPHA=0), MSB-first byte-level slave engine running entirely in the system clock domain. It oversamples the raw SPI pins, assembles received bytes, and shifts out a byte supplied by the downstream register/command stage. It presents a one-cycle `o_rx_done` strobe with `o_rx_data` to that consumer and takes the consumer's response on `i_tx_data`.

---
 rtl/spi_byte_slave.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: SPI mode-0, MSB-first byte slave oversampled in the i_clk domain.
// Define SPI_FRAME_ERR_EN to add the o_frame_err abort strobe.
module spi_byte_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_spi_s_sck,
  input  logic       i_spi_s_cs_n,
  input  logic       i_spi_s_mosi,
  output logic       o_spi_s_miso_oe,
  output logic       o_spi_s_miso,
  output logic       o_rx_done,
  output logic [7:0] o_rx_data,
  input  logic [7:0] i_tx_data
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic       o_frame_err
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_hist;
  logic                   cs_hist;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;

  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] rx_data;
  logic       rx_done;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  // Synchronizers idle at the bus-inactive levels so a CS_n held low across
  // reset release is seen as a fresh falling edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_hist  <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_s_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_s_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_s_mosi};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;
  assign cs_fall  = ~cs_s & cs_hist;
  assign cs_rise  = cs_s & ~cs_hist;

  // o_rx_done is a single-cycle strobe with o_rx_data, no backpressure;
  // i_tx_data is sampled only at frame start and on the falling edge that ends a byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      tx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_done  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      rx_done <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          bit_cnt <= 3'd0;
          if (cs_fall) begin
            state    <= ST_ACTIVE;
            tx_shift <= i_tx_data;
            rx_shift <= 8'h00;
          end
        end
        ST_ACTIVE: begin
          // A CS_n release takes priority over any SCK edge in the same cycle.
          if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= (bit_cnt != 3'd0);
`endif
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data <= {rx_shift[6:0], mosi_s};
              rx_done <= 1'b1;
            end
          end else if (sck_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end else begin
              tx_shift <= i_tx_data;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign o_spi_s_miso_oe = (state == ST_ACTIVE);
  assign o_spi_s_miso    = (state == ST_ACTIVE) & tx_shift[7];
  assign o_rx_done       = rx_done;
  assign o_rx_data       = rx_data;
`ifdef SPI_FRAME_ERR_EN
  assign o_frame_err     = frame_err;
`endif

endmodule
